serial_add_arbiter: RTL

SERIAL_ADD_ARBITER -- requirements
Module: serial_add_arbiter

---
 rtl/serial_add_pkg.sv | 17 +
 rtl/serial_add_core.sv | 71 +++++++
 rtl/serial_add_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial adder arbiter.
//   DEF_WIDTH : default operand width in bits
//   DEF_NREQ  : default number of requesters
//   state_t   : FSM state encoding (IDLE, LOAD, ADD, DONE)
package serial_add_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_NREQ  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/serial_add_core.sv
// Bit-serial ripple adder datapath, one bit per enabled cycle, LSB first.
//   clk, reset_n : clock, asynchronous active-low reset (carry and counter)
//   load         : capture a/b, clear carry and bit counter
//   en           : process one bit this cycle
//   a, b         : operands captured on load
//   sum          : {carry out, result bits} including the bit processed this cycle
//   last         : the bit processed this cycle is the final one
module serial_add_core
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum,
    output logic             last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic             s_bit;
    logic             c_next;
    logic [CW-1:0]    cnt;

    assign s_bit  = a_sr[0] ^ b_sr[0] ^ carry;
    assign c_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

    // Result bits enter at the MSB and move down, so after WIDTH shifts the
    // first-computed bit sits at bit 0.
    assign res_next = (res_sr >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

    // sum is the look-ahead value after the current bit, so the top level can
    // register the complete result on the same edge that ends the last bit.
    assign sum  = {c_next, res_next};
    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            carry <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            carry <= 1'b0;
            cnt   <= '0;
        end else if (en) begin
            carry <= c_next;
            cnt   <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
        end else if (en) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_next;
        end
    end

endmodule

// File: rtl/serial_add_arbiter.sv
// Round-robin arbiter in front of a shared bit-serial adder.
//   clk, reset_n : clock, asynchronous active-low reset
//   req          : per-requester add request
//   a_flat       : operand A, requester i at [i*WIDTH +: WIDTH]
//   b_flat       : operand B, same packing
//   gnt          : one-hot grant, high during the operand capture cycle
//   busy         : FSM not idle
//   sum          : last completed result (WIDTH+1 bits, unsigned)
//   sum_id       : requester that owns sum
//   sum_valid    : one-cycle pulse marking a new sum/sum_id
module serial_add_arbiter
    import serial_add_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int NREQ  = DEF_NREQ,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_flat,
    input  logic [NREQ*WIDTH-1:0] b_flat,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [WIDTH:0]        sum,
    output logic [IDW-1:0]        sum_id,
    output logic                  sum_valid
);

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   win_id;
    logic [IDW-1:0]   pick;
    logic             any_req;
    logic             arb;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   core_sum;
    logic             core_last;

    // Scan from the farthest candidate towards rr_ptr so the nearest
    // requesting index (in wrap order) overwrites earlier hits.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDW-1:0]  ptr);
        logic [IDW-1:0] w;
        int             idx;
        w = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (r[IDW'(idx)]) w = IDW'(idx);
        end
        return w;
    endfunction

    function automatic logic [IDW-1:0] ptr_inc(input logic [IDW-1:0] p);
        return (p == IDW'(NREQ - 1)) ? '0 : p + 1'b1;
    endfunction

    assign any_req = |req;
    assign pick    = rr_pick(req, rr_ptr);
    assign arb     = any_req && ((state == IDLE) || (state == DONE));
    assign busy    = (state != IDLE);
    assign op_a    = a_flat[int'(win_id)*WIDTH +: WIDTH];
    assign op_b    = b_flat[int'(win_id)*WIDTH +: WIDTH];

    serial_add_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (state == LOAD),
        .en      (state == ADD),
        .a       (op_a),
        .b       (op_b),
        .sum     (core_sum),
        .last    (core_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_req) state_nxt = LOAD;
            LOAD: state_nxt = ADD;
            ADD:  if (core_last) state_nxt = DONE;
            DONE: state_nxt = any_req ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt       <= '0;
            win_id    <= '0;
            rr_ptr    <= '0;
            sum       <= '0;
            sum_id    <= '0;
            sum_valid <= 1'b0;
        end else begin
            gnt       <= '0;
            sum_valid <= 1'b0;
            if (arb) begin
                gnt[pick] <= 1'b1;
                win_id    <= pick;
            end
            if (state == LOAD) rr_ptr <= ptr_inc(win_id);
            if ((state == ADD) && core_last) begin
                sum       <= core_sum;
                sum_id    <= win_id;
                sum_valid <= 1'b1;
            end
        end
    end

endmodule
